// File: rtl/sram_arb_pkg.sv
// Shared constants for the SRAM port arbiter: requester ids and FSM state encoding.
package sram_arb_pkg;

  localparam logic ARB_ID_INST = 1'b0;
  localparam logic ARB_ID_DATA = 1'b1;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/arb_id_fifo.sv
// In-order tracking FIFO of 1-bit requester ids; DEPTH must be a power of two.
module arb_id_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     push_id,
  input  logic                     pop,
  output logic                     head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DEPTH-1:0] store;
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;

  assign head  = store[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) store[wptr] <= push_id;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-to-one SRAM port arbiter with in-order response steering.
// Define SRAM_ARB_RR_EN for round-robin arbitration in IDLE (default: data over inst).
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned OT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [3:0]  inst_wstrb,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        arb_err
);

  localparam int unsigned CW = $clog2(OT_DEPTH) + 1;

  arb_state_e    state;
  logic          hold_id;
  logic          idle_pick;
  logic          grant_id;
  logic          granted_req;
  logic          hs;
  logic          pop_ok;
  logic          ot_head;
  logic          ot_full;
  logic          ot_empty;
  logic [CW-1:0] ot_count;

`ifdef SRAM_ARB_RR_EN
  logic last_id;

  // On a tie the requester that lost the previous handshake wins.
  always_comb begin
    idle_pick = ARB_ID_INST;
    if (data_req && inst_req) idle_pick = ~last_id;
    else if (data_req)        idle_pick = ARB_ID_DATA;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)  last_id <= ARB_ID_INST;
    else if (hs)  last_id <= grant_id;
  end
`else
  assign idle_pick = data_req ? ARB_ID_DATA : ARB_ID_INST;
`endif

  assign grant_id    = (state == ARB_HOLD) ? hold_id : idle_pick;
  assign granted_req = (grant_id == ARB_ID_DATA) ? data_req : inst_req;
  assign mem_req     = granted_req & ~ot_full;
  assign hs          = mem_req & mem_addr_ok;

  always_comb begin
    mem_wr    = 1'b0;
    mem_wstrb = '0;
    mem_size  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_req) begin
      if (grant_id == ARB_ID_DATA) begin
        mem_wr    = data_wr;
        mem_wstrb = data_wstrb;
        mem_size  = data_size;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        mem_wr    = inst_wr;
        mem_wstrb = inst_wstrb;
        mem_size  = inst_size;
        mem_addr  = inst_addr;
        mem_wdata = inst_wdata;
      end
    end
  end

  assign inst_addr_ok = hs & (grant_id == ARB_ID_INST);
  assign data_addr_ok = hs & (grant_id == ARB_ID_DATA);

  assign pop_ok       = mem_data_ok & ~ot_empty;
  assign inst_data_ok = pop_ok & (ot_head == ARB_ID_INST);
  assign data_data_ok = pop_ok & (ot_head == ARB_ID_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  arb_id_fifo #(
    .DEPTH (OT_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (hs),
    .push_id (grant_id),
    .pop     (pop_ok),
    .head    (ot_head),
    .full    (ot_full),
    .empty   (ot_empty),
    .count   (ot_count)
  );

  // HOLD also persists while the FIFO is full and the owner keeps requesting.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ARB_IDLE;
      hold_id <= ARB_ID_INST;
      arb_err <= 1'b0;
    end else begin
      if (mem_data_ok && (ot_count == '0)) arb_err <= 1'b1;
      case (state)
        ARB_IDLE: begin
          if (mem_req && !mem_addr_ok) begin
            state   <= ARB_HOLD;
            hold_id <= grant_id;
          end
        end
        ARB_HOLD: begin
          if (hs || !granted_req) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter (default fixed-priority build, OT_DEPTH=4).
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [3:0]  inst_wstrb;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [3:0]  mem_wstrb;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        arb_err;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] IA = 32'h1C00_0000;
  localparam logic [31:0] DA = 32'h1C00_0100;

  always #5 clk = ~clk;

  sram_arbiter #(.OT_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_wstrb(inst_wstrb), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .arb_err(arb_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then changed away from the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    resetn = 1'b0;
    inst_req = 0; inst_wr = 0; inst_wstrb = 4'h0; inst_size = 2'd2; inst_addr = IA; inst_wdata = '0;
    data_req = 0; data_wr = 1; data_wstrb = 4'hF; data_size = 2'd2; data_addr = DA;
    data_wdata = 32'hDEAD_BEEF;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
    tick(); tick();
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
    chk("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
    chk("rst_arb_err", arb_err, 0);
    resetn = 1'b1;
    tick();

    // Data priority on a tie
    inst_req = 1; data_req = 1; mem_addr_ok = 1; #1;
    chk("prio_mem_req", mem_req, 1);
    chk("prio_data_addr_ok", data_addr_ok, 1);
    chk("prio_inst_addr_ok", inst_addr_ok, 0);
    chk("prio_mem_addr", mem_addr, DA);
    chk("prio_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("prio_mem_wr", mem_wr, 1);
    tick();
    inst_req = 0; data_req = 0; mem_addr_ok = 0; #1;
    chk("idle_mem_addr_zero", mem_addr, 0);
    chk("idle_mem_wstrb_zero", mem_wstrb, 0);
    mem_data_ok = 1; mem_rdata = 32'h55; #1;
    chk("prio_data_data_ok", data_data_ok, 1);
    chk("prio_inst_data_ok", inst_data_ok, 0);
    chk("prio_inst_rdata", inst_rdata, 32'h55);
    chk("prio_data_rdata", data_rdata, 32'h55);
    tick();
    mem_data_ok = 0;

    // Grant hold: inst waits, data arrives, inst keeps the port
    inst_req = 1; #1;
    chk("hold0_mem_addr", mem_addr, IA);
    chk("hold0_inst_addr_ok", inst_addr_ok, 0);
    tick();
    data_req = 1; #1;
    chk("hold1_mem_req", mem_req, 1);
    chk("hold1_mem_addr", mem_addr, IA);
    chk("hold1_data_addr_ok", data_addr_ok, 0);
    tick();
    mem_addr_ok = 1; #1;
    chk("hold2_mem_addr", mem_addr, IA);
    chk("hold2_inst_addr_ok", inst_addr_ok, 1);
    chk("hold2_data_addr_ok", data_addr_ok, 0);
    tick();

    // Ordering: queue now holds inst; add data then inst
    inst_req = 0; #1;
    chk("ord_data_addr_ok", data_addr_ok, 1);
    tick();
    data_req = 0; inst_req = 1; #1;
    chk("ord_inst_addr_ok", inst_addr_ok, 1);
    tick();
    inst_req = 0; mem_addr_ok = 0;
    mem_data_ok = 1; mem_rdata = 32'hA; #1;
    chk("ord_A_inst_ok", inst_data_ok, 1);
    chk("ord_A_data_ok", data_data_ok, 0);
    chk("ord_A_rdata", inst_rdata, 32'hA);
    tick();
    mem_rdata = 32'hB; #1;
    chk("ord_B_inst_ok", inst_data_ok, 0);
    chk("ord_B_data_ok", data_data_ok, 1);
    chk("ord_B_rdata", data_rdata, 32'hB);
    tick();
    mem_rdata = 32'hC; #1;
    chk("ord_C_inst_ok", inst_data_ok, 1);
    chk("ord_C_data_ok", data_data_ok, 0);
    tick();
    mem_data_ok = 0;

    // Abandon: held inst drops its request, data may then win
    inst_req = 1; tick();
    inst_req = 0; data_req = 1; #1;
    chk("abandon_mem_req", mem_req, 0);
    tick(); #1;
    chk("abandon_data_mem_req", mem_req, 1);
    chk("abandon_data_addr", mem_addr, DA);
    data_req = 0; tick(); tick();

    // Full FIFO
    data_req = 1; mem_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("full_fill_addr_ok", data_addr_ok, 1);
      tick();
    end
    #1;
    chk("full_mem_req", mem_req, 0);
    chk("full_addr_ok", data_addr_ok, 0);
    chk("full_mem_addr", mem_addr, 0);
    mem_data_ok = 1; #1;
    chk("full_pop_mem_req", mem_req, 0);
    chk("full_pop_data_ok", data_data_ok, 1);
    tick();
    mem_data_ok = 0; #1;
    chk("full_after_pop_mem_req", mem_req, 1);
    chk("full_after_pop_addr_ok", data_addr_ok, 1);
    tick();
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("full_drain_data_ok", data_data_ok, 1);
      tick();
    end

    // Error: response with nothing outstanding
    #1;
    chk("err_inst_data_ok", inst_data_ok, 0);
    chk("err_data_data_ok", data_data_ok, 0);
    chk("err_same_cycle", arb_err, 0);
    tick();
    mem_data_ok = 0; #1;
    chk("err_set", arb_err, 1);
    tick(); #1;
    chk("err_sticky", arb_err, 1);

    // Reset with two outstanding
    data_req = 1; mem_addr_ok = 1; tick(); tick();
    data_req = 0; mem_addr_ok = 0; #1;
    chk("pre_rst_count", dut.u_fifo.count, 2);
    resetn = 0; #1;
    chk("rst2_arb_err", arb_err, 0);
    chk("rst2_count", dut.u_fifo.count, 0);
    chk("rst2_mem_req", mem_req, 0);
    tick();
    resetn = 1; data_req = 1; mem_addr_ok = 1; #1;
    chk("rst2_follow_mem_req", mem_req, 1);
    chk("rst2_follow_addr_ok", data_addr_ok, 1);
    tick();
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; #1;
    chk("rst2_one_resp", data_data_ok, 1);
    tick(); #1;
    chk("rst2_discarded", data_data_ok, 0);
    tick();
    mem_data_ok = 0; #1;
    chk("rst2_err_again", arb_err, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
